// File: rtl/result_drain.sv
// Result-side readout buffer: captures full accumulator rows into a small row FIFO
// and streams each row to the host as OUT_WIDTH-bit words over valid/ready.
module result_drain #(
    parameter int unsigned COL       = 4,
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [COL*ACC_WIDTH-1:0]   in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [OUT_WIDTH-1:0]       out_data,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int unsigned RowWidth  = COL * ACC_WIDTH;
    localparam int unsigned Wpr       = RowWidth / OUT_WIDTH;
    localparam int unsigned PtrWidth  = $clog2(DEPTH);
    localparam int unsigned CntWidth  = $clog2(DEPTH + 1);
    localparam int unsigned WidxWidth = (Wpr > 1) ? $clog2(Wpr) : 1;

    localparam logic [PtrWidth-1:0]  PtrOne   = PtrWidth'(1);
    localparam logic [CntWidth-1:0]  CntOne   = CntWidth'(1);
    localparam logic [CntWidth-1:0]  CntFull  = CntWidth'(DEPTH);
    localparam logic [WidxWidth-1:0] WidxOne  = WidxWidth'(1);
    localparam logic [WidxWidth-1:0] WidxLast = WidxWidth'(Wpr - 1);

    typedef enum logic [0:0] {StEmpty, StStream} state_e;

    state_e                state_q;
    logic [PtrWidth-1:0]   wr_ptr_q;
    logic [PtrWidth-1:0]   rd_ptr_q;
    logic [CntWidth-1:0]   count_q;
    logic [CntWidth-1:0]   count_d;
    logic [WidxWidth-1:0]  widx_q;
    logic                  overflow_q;
    logic [RowWidth-1:0]   mem [DEPTH];

    logic                  full;
    logic                  push;
    logic                  drop;
    logic                  xfer;
    logic                  pop;
    logic [RowWidth-1:0]   head_row;
    logic [OUT_WIDTH-1:0]  head_word;

    // Readiness comes from registered full only; a same-cycle pop never frees a slot.
    assign full      = (count_q == CntFull);
    assign in_ready  = !full;
    assign out_valid = (state_q == StStream);
    assign push      = in_valid && !full;
    assign drop      = in_valid && full;
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && (widx_q == WidxLast);
    assign count     = count_q;
    assign overflow  = overflow_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntOne;
        end else if (pop && !push) begin
            count_d = count_q - CntOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            widx_q     <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            state_q    <= StEmpty;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            widx_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (xfer) begin
                if (widx_q == WidxLast) begin
                    widx_q   <= '0;
                    rd_ptr_q <= rd_ptr_q + PtrOne;
                end else begin
                    widx_q <= widx_q + WidxOne;
                end
            end
            count_q <= count_d;
            unique case (state_q)
                StEmpty:  if (push) state_q <= StStream;
                StStream: if (count_d == '0) state_q <= StEmpty;
            endcase
        end
    end

    // Row storage carries no reset; only the control state above is cleared.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        head_row  = mem[rd_ptr_q];
        head_word = '0;
        for (int k = 0; k < Wpr; k++) begin
            if (widx_q == WidxWidth'(k)) begin
                head_word = head_row[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    // Gate with out_valid so stale, unreset storage never reaches the host.
    assign out_data = out_valid ? head_word : '0;
    assign out_last = out_valid && (widx_q == WidxLast);

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: scoreboard of expected words, one task per scenario.
module tb_result_drain;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        out_last;
    logic [2:0]  count;
    logic        overflow;

    int          n_checks;
    int          n_fail;
    logic [32:0] exp_q [$];
    logic [32:0] tmp;

    result_drain dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_last  (out_last),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input logic [63:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Expected words of an accepted row, lowest word first.
    task automatic sb_push(input logic [63:0] d);
        exp_q.push_back({1'b0, d[31:0]});
        exp_q.push_back({1'b1, d[63:32]});
    endtask

    task automatic test_reset();
        rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        n_checks++;
        if ({out_valid, out_last, in_ready, overflow, count, out_data} !== {3'b001, 1'b0, 3'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b l=%b r=%b o=%b c=%0d d=%h required v=0 l=0 r=1 o=0 c=0 d=0",
                     out_valid, out_last, in_ready, overflow, count, out_data);
        end
        tick(); tick();
        rst_n = 1'b1;
        push_row(64'h1111_2222_3333_4444);
        push_row(64'h5555_6666_7777_8888);
        n_checks++;
        if (count !== 3'd2) begin
            n_fail++; $display("FAIL reset_prefill_count: got %0d required 2", count);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, count, in_ready, overflow, out_data} !== {1'b0, 3'd0, 1'b1, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_async: got v=%b c=%0d r=%b o=%b d=%h required v=0 c=0 r=1 o=0 d=0",
                     out_valid, count, in_ready, overflow, out_data);
        end
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_residual: out_valid got %b required 0", out_valid);
            end
        end
    endtask

    task automatic test_single_row();
        out_ready = 1'b1;
        sb_push(64'h0004_0003_0002_0001);
        push_row(64'h0004_0003_0002_0001);
        n_checks++;
        if ({out_valid, count} !== {1'b1, 3'd1}) begin
            n_fail++; $display("FAIL single_latency: got v=%b c=%0d required v=1 c=1", out_valid, count);
        end
        while (exp_q.size() > 0) begin
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++; $display("FAIL single_valid: got %b required 1", out_valid);
                exp_q.delete();
            end else begin
                n_checks++;
                if ({out_last, out_data} !== exp_q[0]) begin
                    n_fail++; $display("FAIL single_word: got %h required %h", {out_last, out_data}, exp_q[0]);
                end
                tmp = exp_q.pop_front();
                tick();
            end
        end
        n_checks++;
        if ({out_valid, count} !== {1'b0, 3'd0}) begin
            n_fail++; $display("FAIL single_empty: got v=%b c=%0d required v=0 c=0", out_valid, count);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        sb_push(64'h0004_0003_0002_0001);
        push_row(64'h0004_0003_0002_0001);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({out_valid, out_last, out_data} !== {1'b1, exp_q[0]}) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d got v=%b word=%h required v=1 word=%h",
                         i, out_valid, {out_last, out_data}, exp_q[0]);
            end
            tick();
        end
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_valid: got %b required 1", out_valid);
                exp_q.delete();
            end else begin
                n_checks++;
                if ({out_last, out_data} !== exp_q[0]) begin
                    n_fail++; $display("FAIL bp_word: got %h required %h", {out_last, out_data}, exp_q[0]);
                end
                tmp = exp_q.pop_front();
                tick();
            end
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_empty: out_valid got %b required 0", out_valid);
        end
    endtask

    task automatic test_overflow_wrap();
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            sb_push(64'(k));
            push_row(64'(k));
        end
        n_checks++;
        if ({in_ready, count} !== {1'b0, 3'd4}) begin
            n_fail++; $display("FAIL full_state: got r=%b c=%0d required r=0 c=4", in_ready, count);
        end
        push_row(64'd5);
        n_checks++;
        if ({overflow, count} !== {1'b1, 3'd4}) begin
            n_fail++; $display("FAIL overflow_drop: got o=%b c=%0d required o=1 c=4", overflow, count);
        end
        out_ready = 1'b1;
        for (int phase = 0; phase < 3; phase++) begin
            while (exp_q.size() > 0) begin
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_fail++; $display("FAIL wrap_valid: phase %0d got %b required 1", phase, out_valid);
                    exp_q.delete();
                end else begin
                    n_checks++;
                    if ({out_last, out_data} !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL wrap_word: phase %0d got %h required %h",
                                 phase, {out_last, out_data}, exp_q[0]);
                    end
                    tmp = exp_q.pop_front();
                    tick();
                end
            end
            // Two rows then four rows: the second batch straddles the pointer wrap.
            if (phase < 2) begin
                out_ready = 1'b0;
                for (int k = 0; k < 2 + 2 * phase; k++) begin
                    sb_push({32'h0000_00a0 + 32'(k), 32'h0000_0006 + 32'(phase * 2 + k)});
                    push_row({32'h0000_00a0 + 32'(k), 32'h0000_0006 + 32'(phase * 2 + k)});
                end
                out_ready = 1'b1;
            end
        end
        n_checks++;
        if ({out_valid, count, overflow} !== {1'b0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_end: got v=%b c=%0d o=%b required v=0 c=0 o=1", out_valid, count, overflow);
        end
    endtask

    task automatic test_simul_push_pop();
        clear = 1'b1; tick(); clear = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL sim_clear_ovf: got %b required 0", overflow);
        end
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sb_push(64'h21 + 64'(k));
            push_row(64'h21 + 64'(k));
        end
        out_ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            n_checks++;
            if ({out_last, out_data} !== exp_q[0]) begin
                n_fail++; $display("FAIL sim_full_head: got %h required %h", {out_last, out_data}, exp_q[0]);
            end
            tmp = exp_q.pop_front();
            if (w == 1) begin
                in_valid = 1'b1;
                in_data  = 64'h25;
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if ({count, overflow} !== {3'd3, 1'b1}) begin
            n_fail++; $display("FAIL sim_full_pop: got c=%0d o=%b required c=3 o=1", count, overflow);
        end
        while (exp_q.size() > 0) begin
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++; $display("FAIL sim_valid: got %b required 1", out_valid);
                exp_q.delete();
            end else begin
                n_checks++;
                if ({out_last, out_data} !== exp_q[0]) begin
                    n_fail++; $display("FAIL sim_word: got %h required %h", {out_last, out_data}, exp_q[0]);
                end
                tmp = exp_q.pop_front();
                tick();
            end
        end
        clear = 1'b1; tick(); clear = 1'b0;
        out_ready = 1'b0;
        sb_push(64'h31); push_row(64'h31);
        sb_push(64'h32); push_row(64'h32);
        out_ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            n_checks++;
            if ({out_last, out_data} !== exp_q[0]) begin
                n_fail++; $display("FAIL sim_two_head: got %h required %h", {out_last, out_data}, exp_q[0]);
            end
            tmp = exp_q.pop_front();
            if (w == 1) begin
                in_valid = 1'b1;
                in_data  = 64'h33;
            end
            tick();
        end
        in_valid = 1'b0;
        sb_push(64'h33);
        n_checks++;
        if ({count, overflow} !== {3'd2, 1'b0}) begin
            n_fail++; $display("FAIL sim_two_count: got c=%0d o=%b required c=2 o=0", count, overflow);
        end
        while (exp_q.size() > 0) begin
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++; $display("FAIL sim_two_valid: got %b required 1", out_valid);
                exp_q.delete();
            end else begin
                n_checks++;
                if ({out_last, out_data} !== exp_q[0]) begin
                    n_fail++; $display("FAIL sim_two_word: got %h required %h", {out_last, out_data}, exp_q[0]);
                end
                tmp = exp_q.pop_front();
                tick();
            end
        end
    endtask

    task automatic test_clear();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_row(64'h41 + 64'(k));
        end
        clear = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        n_checks++;
        if ({overflow, count} !== {1'b1, 3'd0}) begin
            n_fail++; $display("FAIL clr_setup: got o=%b c=%0d required o=1 c=0", overflow, count);
        end
        out_ready = 1'b0;
        sb_push(64'h0000_0052_0000_0051);
        push_row(64'h0000_0052_0000_0051);
        out_ready = 1'b1;
        n_checks++;
        if ({out_last, out_data} !== exp_q[0]) begin
            n_fail++; $display("FAIL clr_word0: got %h required %h", {out_last, out_data}, exp_q[0]);
        end
        tick();
        exp_q.delete();
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h99;
        out_ready = 1'b0;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if ({count, out_valid, out_last, overflow, in_ready} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL clr_state: got c=%0d v=%b l=%b o=%b r=%b required c=0 v=0 l=0 o=0 r=1",
                     count, out_valid, out_last, overflow, in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL clr_row_dropped: out_valid got %b required 0", out_valid);
        end
        sb_push(64'h0000_0062_0000_0061);
        push_row(64'h0000_0062_0000_0061);
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++; $display("FAIL clr_valid: got %b required 1", out_valid);
                exp_q.delete();
            end else begin
                n_checks++;
                if ({out_last, out_data} !== exp_q[0]) begin
                    n_fail++; $display("FAIL clr_word: got %h required %h", {out_last, out_data}, exp_q[0]);
                end
                tmp = exp_q.pop_front();
                tick();
            end
        end
        n_checks++;
        if ({out_valid, count} !== {1'b0, 3'd0}) begin
            n_fail++; $display("FAIL clr_end: got v=%b c=%0d required v=0 c=0", out_valid, count);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_row();
        test_backpressure();
        test_overflow_wrap();
        test_simul_push_pop();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/result_drain.md
# result_drain

Result-side readout buffer for the mini TPU. It captures complete output rows from the bottom of the systolic array (COL accumulators, ACC_WIDTH bits each) into a small row FIFO. It then streams each row to the host as OUT_WIDTH-bit words over a valid/ready handshake. It is the read-out counterpart of the host's 32-bit write path into the activation buffer.

## Interface
- COL, default 4: accumulator columns per row.
- ACC_WIDTH, default 16: bits per accumulator.
- OUT_WIDTH, default 32: host word width. COL*ACC_WIDTH must be an integer multiple of it; WPR = COL*ACC_WIDTH/OUT_WIDTH (default 2).
- DEPTH, default 4: rows buffered. Must be a power of two, ≥2.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- clear  in  1  synchronous flush of FIFO, word index and overflow flag.
- in_valid  in  1  array row strobe; one row per asserted cycle.
- in_data  in  COL*ACC_WIDTH  row; column 0 in bits [ACC_WIDTH-1:0].
- in_ready  out  1  high when FIFO not full.
- out_valid  out  1  current word available.
- out_data  out  OUT_WIDTH  current word.
- out_ready  in  1  host accepts word.
- out_last  out  1  current word is the last word of its row.
- count  out  $clog2(DEPTH+1)  rows held, including a partially drained row.
- overflow  out  1  sticky: a row arrived while full.

## Operation
- Storage: DEPTH-entry row array, write pointer wr_ptr, read pointer rd_ptr, count register, word index widx in 0..WPR-1.
- Push: in_valid && in_ready writes in_data at wr_ptr, and wr_ptr increments modulo DEPTH (wraps DEPTH-1→0).
- Drop: in_valid && !in_ready discards the row, sets overflow, and leaves pointers and count unchanged.
- in_ready = (count != DEPTH). It depends only on registered full, not on a same-cycle pop. A push while full is dropped even if a pop occurs that cycle.
- Drain FSM:
  - EMPTY: count==0, out_valid=0.
  - STREAM: count>0, out_valid=1.
  - EMPTY→STREAM after the first push.
  - STREAM→EMPTY when the last word of the only row is accepted and no push occurs that cycle.
- out_data = word widx of the row at rd_ptr. Word k is in_data[(k+1)*OUT_WIDTH-1 : k*OUT_WIDTH], lowest word first.
- out_last = out_valid && (widx == WPR-1).
- Transfer = out_valid && out_ready.
  - On transfer with widx < WPR-1: widx increments.
  - On transfer with widx == WPR-1: widx←0, rd_ptr increments modulo DEPTH, and the row pops.
- Simultaneous push and pop: count unchanged, both pointers advance.
- count: +1 on push only, −1 on pop only, unchanged otherwise.
- clear has priority over push, pop and drop in the same cycle:
  - pointers, count and widx go to 0, and overflow goes to 0;
  - a row presented in the clear cycle is discarded and does not set overflow.
- Storage contents are not reset; only control state is.

## Timing
- Reset (rst_n=0, asynchronous, any cycle including mid-row): out_valid=0, out_last=0, out_data=0, in_ready=1, count=0, overflow=0, widx=0, pointers=0.
- Push at edge N: out_valid=1 and count=1 from after edge N. Latency is one cycle, with no bypass in the push cycle.
- Throughput: one word per cycle with out_ready held high; a full row takes WPR cycles.
- out_data, out_last and out_valid are stable while out_valid && !out_ready. They change only after a transfer, clear or reset.
- out_data, out_valid, out_last, in_ready and count are functions of registered state only, with no combinational path from in_valid or out_ready.
- overflow sets on the edge after the dropped strobe, and holds until clear or reset.

## Test plan
- Reset: assert rst_n=0 mid-stream with 2 rows held, no clock edge → immediately out_valid=0, count=0, in_ready=1, overflow=0. After release, no residual words.
- Single row: push in_data=64'h0004_0003_0002_0001, out_ready=1 → next cycle out_data=32'h0002_0001 with out_last=0, then 32'h0004_0003 with out_last=1, then out_valid=0, count=0.
- Backpressure: same row with out_ready=0 for 5 cycles → out_data holds 32'h0002_0001 and out_valid stays 1 throughout. Raising out_ready then delivers both words in order.
- Full/overflow/wrap: push 4 rows (values 1..4 in column 0), then a 5th (value 5) → in_ready=0 after the 4th, 5th dropped, overflow=1, count=4. Drain all 8 words → column-0 words read 1,2,3,4. Push 6 more rows across the wrap → read back in order.
- Simultaneous push/pop: count=4 while popping the last word of the head row with in_valid high → row dropped, overflow set, count=3. Repeat at count=2 → row accepted, count stays 2.
- Clear mid-row: after word 0 of a row is accepted, assert clear together with in_valid → next cycle count=0, out_valid=0, widx=0, overflow=0. The clear-cycle row is not stored.
